nios2_dbg_cmd_dispatch: RTL and testbench

//  Debug-module command dispatcher on the system-clock side, parametrised successor to the fixed 2-bit-IR/38-bit sysclk decoder.

---
 rtl/nios2_dbg_cmd_dispatch.sv | 160 ++++++++++++++++
 tb/tb_nios2_dbg_cmd_dispatch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_dbg_cmd_dispatch.sv
// Debug command dispatcher on the system-clock side.
// Synchronises the virtual-JTAG UIR/UDR levels, captures {IR, shift data} on the
// UDR edge into a small FIFO, and hands each command to the core as a one-cycle
// take_action / take_no_action strobe on the channel selected by its IR.
// Optional build macro DBG_CMD_PARITY_EN: the top data bit carries even parity.
// A command that fails the check is dropped and parity_err is set.
module nios2_dbg_cmd_dispatch #(
  parameter int IR_W        = 2,
  parameter int DATA_W      = 38,
  parameter int ACT_BIT     = 35,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int NCH = 2 ** IR_W,
  localparam int LW  = $clog2(DEPTH) + 1,
  localparam int PW  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  input  logic              vs_udr,
  input  logic              vs_uir,
  input  logic              core_ready,
  input  logic              ovf_clr,
  output logic [DATA_W-1:0] jdo,
  output logic [NCH-1:0]    take_action,
  output logic [NCH-1:0]    take_no_action,
  output logic [LW-1:0]     fifo_level,
  output logic              ovf_sticky,
  output logic              parity_err
);

  typedef struct packed {
    logic [IR_W-1:0]   ir;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic {IDLE, ISSUE} state_t;

  // The top bit of each pipe is the edge-detect flop behind the synchroniser.
  logic [SYNC_STAGES:0] uir_pipe, udr_pipe;
  logic                 uir_edge, udr_edge;
  logic [IR_W-1:0]      ir_q;
  cmd_t                 mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  cmd_t                 push_data, head;
  logic                 par_ok, push_req, push, pop, full, drop;
  logic [NCH-1:0]       ch_oh;
  state_t               state;

  assign uir_edge = uir_pipe[SYNC_STAGES-1] & ~uir_pipe[SYNC_STAGES];
  assign udr_edge = udr_pipe[SYNC_STAGES-1] & ~udr_pipe[SYNC_STAGES];

  // Coincident UIR/UDR: the pushed entry must see the new IR, not stale ir_q.
  assign push_data.ir = uir_edge ? ir_in : ir_q;
`ifdef DBG_CMD_PARITY_EN
  assign par_ok         = ~^sr;
  assign push_data.data = {1'b0, sr[DATA_W-2:0]};
`else
  assign par_ok         = 1'b1;
  assign push_data.data = sr;
`endif

  assign head     = mem[rd_ptr];
  assign ch_oh    = {{(NCH-1){1'b0}}, 1'b1} << head.ir;
  assign full     = (fifo_level == LW'(DEPTH));
  assign pop      = (state == IDLE) && (fifo_level != '0) && core_ready;
  assign push_req = udr_edge && par_ok;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  // Synchronisers, edge-detect flops and IR capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_pipe <= '0;
      udr_pipe <= '0;
      ir_q     <= '0;
    end else begin
      uir_pipe <= {uir_pipe[SYNC_STAGES-1:0], vs_uir};
      udr_pipe <= {udr_pipe[SYNC_STAGES-1:0], vs_udr};
      if (uir_edge) ir_q <= ir_in;
    end
  end

  // FIFO storage; contents need no reset because the pointers are flushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is 2**PW.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Dispatch FSM: pop in IDLE, strobe is high for exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            jdo            <= head.data;
            take_action    <= head.data[ACT_BIT] ? ch_oh : '0;
            take_no_action <= head.data[ACT_BIT] ? '0 : ch_oh;
            state          <= ISSUE;
          end
        end
        default: begin
          take_action    <= '0;
          take_no_action <= '0;
          state          <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a set event wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
    end
  end

`ifdef DBG_CMD_PARITY_EN
  // Parity failure flag, cleared alongside the overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      parity_err <= 1'b0;
    end else if (udr_edge && !par_ok) begin
      parity_err <= 1'b1;
    end else if (ovf_clr) begin
      parity_err <= 1'b0;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_nios2_dbg_cmd_dispatch.sv
// Scoreboard bench for nios2_dbg_cmd_dispatch (default parameters).
module tb_nios2_dbg_cmd_dispatch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        vs_udr = 1'b0, vs_uir = 1'b0, core_ready = 1'b0, ovf_clr = 1'b0;
  logic [37:0] jdo;
  logic [3:0]  take_action, take_no_action;
  logic [2:0]  fifo_level;
  logic        ovf_sticky, parity_err;

  nios2_dbg_cmd_dispatch dut (
    .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .sr(sr),
    .vs_udr(vs_udr), .vs_uir(vs_uir), .core_ready(core_ready), .ovf_clr(ovf_clr),
    .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
    .fifo_level(fifo_level), .ovf_sticky(ovf_sticky), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ta;
    logic [3:0]  tna;
    logic [37:0] jdo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_strobe = -100;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && ((take_action | take_no_action) != 4'b0)) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected ta=%b tna=%b jdo=%h (none queued)",
                 take_action, take_no_action, jdo);
      end else begin
        e = exp_q.pop_front();
        if (take_action !== e.ta || take_no_action !== e.tna || jdo !== e.jdo) begin
          errors++;
          $display("FAIL strobe_cmp actual ta=%b tna=%b jdo=%h expected ta=%b tna=%b jdo=%h",
                   take_action, take_no_action, jdo, e.ta, e.tna, e.jdo);
        end
      end
      checks++;
      if (cyc - last_strobe < 2) begin
        errors++;
        $display("FAIL strobe_gap actual %0d expected >=2", cyc - last_strobe);
      end
      last_strobe = cyc;
    end
  end

  function automatic logic [37:0] mk(input logic [37:0] b);
`ifdef DBG_CMD_PARITY_EN
    mk = {^b[36:0], b[36:0]};
`else
    mk = b;
`endif
  endfunction

  task automatic push_exp(input logic [1:0] ir, input logic [37:0] d);
    exp_t e;
    logic [3:0] oh;
    oh = 4'b0001 << ir;
    e.jdo = d;
`ifdef DBG_CMD_PARITY_EN
    e.jdo[37] = 1'b0;
`endif
    e.ta  = d[35] ? oh : 4'b0;
    e.tna = d[35] ? 4'b0 : oh;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic uir_pulse(input logic [1:0] ir);
    ir_in = ir; vs_uir = 1'b1; tick(3); vs_uir = 1'b0; tick(3);
  endtask

  task automatic udr_pulse(input logic [37:0] d);
    sr = d; vs_udr = 1'b1; tick(3); vs_udr = 1'b0; tick(3);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((fifo_level != 0 || (take_action | take_no_action) != 0) && n < 100) begin
      tick(1); n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL drain_timeout actual level=%0d expected 0", fifo_level);
    end
    tick(2);
  endtask

  logic [37:0] d;

  initial begin
    // Reset state
    #2;
    chk("rst_ta", take_action, 0);
    chk("rst_tna", take_no_action, 0);
    chk("rst_jdo", jdo, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_par", parity_err, 0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Action on channel 1, with latency check
    core_ready = 1'b1;
    uir_pulse(2'b01);
    d = mk(38'h28_1234_5678);
    push_exp(2'b01, d);
    sr = d; vs_udr = 1'b1;
    tick(3);
    chk("lat_push_level", fifo_level, 1);
    tick(1);
    chk("lat_strobe", take_action, 4'b0010);
    vs_udr = 1'b0;
    tick(3);
    wait_drain();

    // Overflow: five pushes into a 4-deep FIFO with the core stalled
    core_ready = 1'b0;
    uir_pulse(2'b10);
    for (int i = 0; i < 4; i++) begin
      d = mk(38'h10 + 38'(i) + ((i % 2) != 0 ? 38'h8_0000_0000 : 38'h0));
      push_exp(2'b10, d);
      udr_pulse(d);
    end
    chk("full_level", fifo_level, 4);
    chk("full_no_ovf", ovf_sticky, 0);
    sr = mk(38'h3F); vs_udr = 1'b1;
    tick(2);
    ovf_clr = 1'b1;
    tick(1);
    chk("ovf_set_wins", ovf_sticky, 1);
    chk("ovf_level", fifo_level, 4);
    ovf_clr = 1'b0; vs_udr = 1'b0;
    tick(3);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    chk("ovf_clr", ovf_sticky, 0);
    core_ready = 1'b1;
    wait_drain();

    // Coincident UIR and UDR: the new IR (3) must be used, not stale 2
    d = mk(38'h0_5555_AAAA);
    push_exp(2'b11, d);
    ir_in = 2'b11; sr = d; vs_uir = 1'b1; vs_udr = 1'b1;
    tick(3);
    vs_uir = 1'b0; vs_udr = 1'b0;
    tick(3);
    wait_drain();

    // Full FIFO, push in the same cycle as a pop
    core_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = mk(38'h100 + 38'(i) + (i == 2 ? 38'h8_0000_0000 : 38'h0));
      push_exp(2'b11, d);
      udr_pulse(d);
    end
    d = mk(38'h8_0000_0BEE);
    push_exp(2'b11, d);
    sr = d; vs_udr = 1'b1;
    tick(2);
    core_ready = 1'b1;
    tick(1);
    chk("pushpop_level", fifo_level, 4);
    chk("pushpop_ovf", ovf_sticky, 0);
    vs_udr = 1'b0;
    tick(3);
    wait_drain();

`ifdef DBG_CMD_PARITY_EN
    // Bad parity is dropped and flagged
    d = mk(38'h8_0000_0077);
    d[37] = ~d[37];
    udr_pulse(d);
    tick(4);
    chk("par_err_set", parity_err, 1);
    chk("par_level", fifo_level, 0);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    chk("par_err_clr", parity_err, 0);
`else
    chk("par_tied0", parity_err, 0);
`endif

    // Reset during ISSUE: strobe and queue are cleared at once
    core_ready = 1'b0;
    udr_pulse(mk(38'h8_0000_0001));
    udr_pulse(mk(38'h8_0000_0002));
    core_ready = 1'b1;
    begin
      int n = 0;
      while ((take_action | take_no_action) == 0 && n < 50) begin
        tick(1); n++;
      end
      checks++;
      if (n >= 50) begin
        errors++;
        $display("FAIL issue_timeout actual no strobe expected strobe");
      end
    end
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_ta", take_action, 0);
    chk("midrst_tna", take_no_action, 0);
    chk("midrst_level", fifo_level, 0);
    chk("midrst_jdo", jdo, 0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    chk("post_rst_level", fifo_level, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
